// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: state encoding, BCD digit widths, timer sizing.
package alarm_pkg;

    localparam int unsigned MU_W     = 4;
    localparam int unsigned MT_W     = 3;
    localparam int unsigned HU_W     = 4;
    localparam int unsigned HT_W     = 3;
    localparam int unsigned MAX_MIN  = 59;
    localparam int unsigned MAX_HOUR = 23;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    // Four BCD digits of an HH:MM time, most significant digit first.
    typedef struct packed {
        logic [HT_W-1:0] hour_tens;
        logic [HU_W-1:0] hour_units;
        logic [MT_W-1:0] min_tens;
        logic [MU_W-1:0] min_units;
    } hhmm_t;

    // Width needed to hold the larger of the two timeout loads.
    function automatic int unsigned tmr_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable seconds down-counter; expire_c flags the tick that would take the count from 1 to 0.
module tick_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire_c
);

    logic [W-1:0] count;

    // Load wins over tick; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire_c = tick && (count == W'(1));

endmodule

// File: rtl/alarm_controller.sv
// Alarm time storage, minute-match trigger and ring/snooze/stop state machine driving the buzzer.
// Optional ALARM_BEEP_EN: buzzer pulses 1 s on / 1 s off while ringing instead of a steady tone.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] min_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] hour_units,
    input  logic [2:0] hour_tens,
    input  logic       alarm_enable,
    input  logic       set_alarm,
    input  logic [5:0] alarm_minutes,
    input  logic [4:0] alarm_hours,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [3:0] alm_min_units,
    output logic [2:0] alm_min_tens,
    output logic [3:0] alm_hour_units,
    output logic [2:0] alm_hour_tens
);

    localparam int unsigned TMR_W = tmr_width(SNOOZE_SEC, RING_SEC);

    state_t             state, state_nxt;
    hhmm_t              alm, cur, ld;
    logic               ld_valid_c;
    logic               match_r, match_prev;
    logic               trig_c;
    logic               tmr_load, tmr_tick, tmr_expire;
    logic [TMR_W-1:0]   tmr_val;
    logic               buzzer_nxt;

    assign cur = {hour_tens, hour_units, min_tens, min_units};

    // Binary alarm time split into BCD digits; out-of-range loads are dropped.
    always_comb begin
        ld.min_units  = 4'(alarm_minutes % 6'd10);
        ld.min_tens   = 3'(alarm_minutes / 6'd10);
        ld.hour_units = 4'(alarm_hours % 5'd10);
        ld.hour_tens  = 3'(alarm_hours / 5'd10);
    end

    assign ld_valid_c = set_alarm
                      && (alarm_minutes <= 6'(MAX_MIN))
                      && (alarm_hours   <= 5'(MAX_HOUR));

    assign trig_c   = match_r && !match_prev;
    assign tmr_tick = tick_1hz && ((state == RINGING) || (state == SNOOZE));

    tick_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tick     (tmr_tick),
        .expire_c (tmr_expire)
    );

    // Next-state and timer-load decode.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = TMR_W'(RING_SEC);
        if (!alarm_enable) begin
            state_nxt = IDLE;
        end else if (ld_valid_c && ((state == RINGING) || (state == SNOOZE))) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                IDLE: state_nxt = ARMED;
                ARMED: begin
                    if (trig_c && !ld_valid_c) begin
                        state_nxt = RINGING;
                        tmr_load  = 1'b1;
                    end
                end
                RINGING: begin
                    if (stop_btn) begin
                        state_nxt = ARMED;
                    end else if (snooze_btn) begin
                        state_nxt = SNOOZE;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(SNOOZE_SEC);
                    end else if (tmr_expire) begin
                        state_nxt = ARMED;
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_nxt = ARMED;
                    end else if (tmr_expire) begin
                        state_nxt = RINGING;
                        tmr_load  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_EN
    logic beep_phase, beep_nxt;

    // Phase restarts high on every entry to RINGING so each ring begins audible.
    always_comb begin
        beep_nxt = beep_phase;
        if ((state_nxt == RINGING) && (state != RINGING)) begin
            beep_nxt = 1'b1;
        end else if (tick_1hz) begin
            beep_nxt = !beep_phase;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            beep_phase <= 1'b0;
        end else begin
            beep_phase <= beep_nxt;
        end
    end

    assign buzzer_nxt = (state_nxt == RINGING) && beep_nxt;
`else
    assign buzzer_nxt = (state_nxt == RINGING);
`endif

    // A valid load seeds both match flops with the new equality so it cannot look like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            alm        <= '0;
            match_r    <= 1'b0;
            match_prev <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ringing  <= (state_nxt == RINGING);
            snoozing <= (state_nxt == SNOOZE);
            buzzer   <= buzzer_nxt;
            if (ld_valid_c) begin
                alm        <= ld;
                match_r    <= (cur == ld);
                match_prev <= (cur == ld);
            end else begin
                match_r    <= (cur == alm);
                match_prev <= match_r;
            end
        end
    end

    assign alm_min_units  = alm.min_units;
    assign alm_min_tens   = alm.min_tens;
    assign alm_hour_units = alm.hour_units;
    assign alm_hour_tens  = alm.hour_tens;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with short timeouts (SNOOZE_SEC=3, RING_SEC=2).
module tb_alarm_controller;

`ifdef ALARM_BEEP_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [3:0] min_units;
    logic [2:0] min_tens;
    logic [3:0] hour_units;
    logic [2:0] hour_tens;
    logic       alarm_enable;
    logic       set_alarm;
    logic [5:0] alarm_minutes;
    logic [4:0] alarm_hours;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer, ringing, snoozing;
    logic [3:0] alm_min_units, alm_hour_units;
    logic [2:0] alm_min_tens, alm_hour_tens;

    always #5 clk = ~clk;

    alarm_controller #(.SNOOZE_SEC(3), .RING_SEC(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .min_units      (min_units),
        .min_tens       (min_tens),
        .hour_units     (hour_units),
        .hour_tens      (hour_tens),
        .alarm_enable   (alarm_enable),
        .set_alarm      (set_alarm),
        .alarm_minutes  (alarm_minutes),
        .alarm_hours    (alarm_hours),
        .snooze_btn     (snooze_btn),
        .stop_btn       (stop_btn),
        .buzzer         (buzzer),
        .ringing        (ringing),
        .snoozing       (snoozing),
        .alm_min_units  (alm_min_units),
        .alm_min_tens   (alm_min_tens),
        .alm_hour_units (alm_hour_units),
        .alm_hour_tens  (alm_hour_tens)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [2:0]  exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Expected buzzer level while ringing with the given beep phase.
    function automatic logic bz(input logic phase);
        return BEEP ? phase : 1'b1;
    endfunction

    task automatic set_time(input int h, input int m);
        hour_tens  = 3'(h / 10);
        hour_units = 4'(h % 10);
        min_tens   = 3'(m / 10);
        min_units  = 4'(m % 10);
    endtask

    // Push expectation, clock one edge, then pop and compare the registered outputs.
    task automatic step(input string tag, input logic tk, input logic r, input logic s, input logic b);
        logic [2:0] e;
        string      t;
        tick_1hz = tk;
        exp_q.push_back({r, s, b});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        tick_1hz   = 1'b0;
        set_alarm  = 1'b0;
        snooze_btn = 1'b0;
        stop_btn   = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, "/ringing"},  8'(ringing),  8'(e[2]));
        check({t, "/snoozing"}, 8'(snoozing), 8'(e[1]));
        check({t, "/buzzer"},   8'(buzzer),   8'(e[0]));
    endtask

    task automatic check_alm(input string tag, input int h, input int m);
        check({tag, "/alm_mu"}, 8'(alm_min_units),  8'(m % 10));
        check({tag, "/alm_mt"}, 8'(alm_min_tens),   8'(m / 10));
        check({tag, "/alm_hu"}, 8'(alm_hour_units), 8'(h % 10));
        check({tag, "/alm_ht"}, 8'(alm_hour_tens),  8'(h / 10));
    endtask

    // Load alarm h:m one minute early, reach h:m, and expect ringing two edges later.
    task automatic ring_at(input string tag, input int h, input int m);
        set_time(h, m - 1);
        alarm_hours   = 5'(h);
        alarm_minutes = 6'(m);
        set_alarm     = 1'b1;
        step({tag, "_load"}, 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(h, m);
        step({tag, "_match"}, 1'b0, 1'b0, 1'b0, 1'b0);
        step({tag, "_ring"}, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        reset         = 1'b0;
        tick_1hz      = 1'b0;
        set_alarm     = 1'b0;
        snooze_btn    = 1'b0;
        stop_btn      = 1'b0;
        alarm_enable  = 1'b0;
        alarm_minutes = '0;
        alarm_hours   = '0;
        set_time(0, 0);

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            alarm_enable  = 1'($urandom);
            set_alarm     = 1'($urandom);
            snooze_btn    = 1'($urandom);
            stop_btn      = 1'($urandom);
            alarm_minutes = 6'($urandom);
            alarm_hours   = 5'($urandom);
            min_units     = 4'($urandom);
            min_tens      = 3'($urandom);
            hour_units    = 4'($urandom);
            hour_tens     = 3'($urandom);
            step("t1_reset", 1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        check_alm("t1", 0, 0);

        reset        = 1'b1;
        alarm_enable = 1'b0;
        set_time(6, 0);
        step("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // T2: basic ring, stop, no retrigger within the same minute
        alarm_enable = 1'b1;
        step("t2_arm", 1'b0, 1'b0, 1'b0, 1'b0);
        ring_at("t2", 7, 30);
        check_alm("t2", 7, 30);
        stop_btn = 1'b1;
        step("t2_stop", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) step("t2_hold", 1'b1, 1'b0, 1'b0, 1'b0);

        // T3: snooze for 3 ticks (snooze ignored while snoozing), then unanswered ring times out
        ring_at("t3", 7, 32);
        snooze_btn = 1'b1;
        step("t3_snz", 1'b0, 1'b0, 1'b1, 1'b0);
        step("t3_snz_t1", 1'b1, 1'b0, 1'b1, 1'b0);
        snooze_btn = 1'b1;
        step("t3_snz_t2", 1'b1, 1'b0, 1'b1, 1'b0);
        step("t3_rering", 1'b1, 1'b1, 1'b0, bz(1'b1));
        step("t3_ring_t1", 1'b1, 1'b1, 1'b0, bz(1'b0));
        step("t3_timeout", 1'b1, 1'b0, 1'b0, 1'b0);
        step("t3_armed", 1'b1, 1'b0, 1'b0, 1'b0);

        // T4: stop beats snooze; disable while snoozing
        ring_at("t4", 7, 34);
        stop_btn   = 1'b1;
        snooze_btn = 1'b1;
        step("t4_both", 1'b0, 1'b0, 1'b0, 1'b0);
        step("t4_after", 1'b0, 1'b0, 1'b0, 1'b0);
        ring_at("t4b", 7, 36);
        snooze_btn = 1'b1;
        step("t4b_snz", 1'b0, 1'b0, 1'b1, 1'b0);
        alarm_enable = 1'b0;
        step("t4b_dis", 1'b0, 1'b0, 1'b0, 1'b0);
        alarm_enable = 1'b1;
        step("t4b_en", 1'b0, 1'b0, 1'b0, 1'b0);

        // T5: out-of-range loads ignored; load equal to current time does not ring
        alarm_minutes = 6'd60;
        alarm_hours   = 5'd7;
        set_alarm     = 1'b1;
        step("t5_min60", 1'b0, 1'b0, 1'b0, 1'b0);
        check_alm("t5_min60", 7, 36);
        alarm_minutes = 6'd0;
        alarm_hours   = 5'd24;
        set_alarm     = 1'b1;
        step("t5_hr24", 1'b0, 1'b0, 1'b0, 1'b0);
        check_alm("t5_hr24", 7, 36);
        set_time(11, 59);
        step("t5_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(12, 0);
        alarm_minutes = 6'd0;
        alarm_hours   = 5'd12;
        set_alarm     = 1'b1;
        step("t5_eqload", 1'b0, 1'b0, 1'b0, 1'b0);
        check_alm("t5_eqload", 12, 0);
        for (int i = 0; i < 4; i++) step("t5_quiet", 1'b1, 1'b0, 1'b0, 1'b0);

        // Alarm still fires when the stored time is reached afresh
        set_time(12, 1);
        step("t5_away", 1'b0, 1'b0, 1'b0, 1'b0);
        set_time(12, 0);
        step("t5_back", 1'b0, 1'b0, 1'b0, 1'b0);
        step("t5_ring", 1'b0, 1'b1, 1'b0, 1'b1);

        // T6: beep phase toggles per tick while ringing (steady without the option)
        stop_btn = 1'b1;
        step("t6_stop", 1'b0, 1'b0, 1'b0, 1'b0);
        ring_at("t6", 12, 10);
        step("t6_hold", 1'b0, 1'b1, 1'b0, bz(1'b1));
        step("t6_tick1", 1'b1, 1'b1, 1'b0, bz(1'b0));
        step("t6_expire", 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
